mul_fp16_pipe: RTL and testbench
================================

Name: mul_fp16_pipe

Overview:
- Two-stage pipelined IEEE-754 binary16 multiplier with valid/ready handshake.
- Sits directly upstream of the systolic-array fp16 adder in each MAC processing element.
- Its product, paired with the partial sum, is the adder's operand.
- A sideband tag travels with each operation so PE control can track row/column/accumulate info.

Parameters:
- TAG_W, 4, width of sideband tag carried alongside each operation.
- QNAN, 16'h7E00, canonical quiet-NaN pattern emitted for all NaN results.

Ports:
- clk  in  1  system clock, rising edge.
- nRST  in  1  reset; synchronous, active-low.
- in_valid  in  1  operands/tag valid this cycle.
- in_ready  out  1  block can accept; transfer when in_valid & in_ready.
- a_in  in  16  fp16 operand A.
- b_in  in  16  fp16 operand B.
- tag_in  in  TAG_W  sideband, returned unchanged with result.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts; transfer when out_valid & out_ready.
- prod_out  out  16  fp16 product.
- tag_out  out  TAG_W  tag of the result on prod_out.

Behaviour:
- Reset:
  - Synchronous on clk rising edge while nRST=0.
  - s1_v, s2_v, out_valid <= 0; prod_out, tag_out, and all stage registers <= 0.
  - in_ready = 1 in the first cycle after reset.
- Reset mid-operation: all in-flight results are discarded, nothing is emitted, and no partial state survives.
- Handshake:
  - adv2 = !s2_v | out_ready.
  - adv1 = !s1_v | adv2.
  - in_ready = adv1, combinational from out_ready.
  - Stage 1 loads on adv1, with s1_v <= in_valid. Stage 2 loads on adv2, with s2_v <= s1_v.
  - Stalled stages hold their data exactly. There is no drop and no duplication.
- Latency and throughput:
  - 2 cycles from accepted input to out_valid when unstalled.
  - Throughput 1/cycle; 2 operations are buffered under full backpressure.
- out_valid = s2_v. prod_out and tag_out stay stable while out_valid & !out_ready.
- Stage 1 (decode + multiply):
  - sign = sa ^ sb.
  - eff exponent = 1 when the field is 0, else the field.
  - Hidden bit = 0 for subnormal, 1 for normal.
  - P = {hA,fA} * {hB,fB} (11x11 -> 22 bits).
  - esum = effA + effB - 15, 7-bit signed.
  - Register the special-case flag and special value alongside.
- Special cases, evaluated in this priority:
  - Any NaN -> QNAN.
  - Inf*zero -> QNAN.
  - Inf*(finite or Inf) -> {sign,5'h1F,0}.
  - Zero*finite -> {sign,15'b0}.
- Stage 2 (normalize + round):
  - lz = leading zeros of P.
  - N = P << lz, so N[21]=1.
  - e = esum + 1 - lz.
  - frac = N[20:11], G = N[10], S = |N[9:0].
  - RNE: increment when G & (S | frac[0]).
  - A fraction carry-out sets frac=0 and e=e+1.
- Boundary conditions:
  - e >= 31 after rounding -> signed Inf 0x7C00/0xFC00.
  - e <= 0 before rounding -> signed zero (flush-to-zero output; subnormal results are never produced).
  - Subnormal inputs are fully supported.
  - P == 0 -> signed zero.
- Exact zero sign follows sign xor: -0 * +x = -0.

Decomposition:
- Package fp16_pkg:
  - field widths EXP_W=5, FRAC_W=10; BIAS=15.
  - EXP_MAX=5'h1F; QNAN_DEFAULT=16'h7E00.
  - fp16_t struct packed {sign, exp, frac}.
  - A decode function returning is_nan/is_inf/is_zero/is_sub.
- Sub-module lzc22: combinational 22-bit leading-zero counter with 5-bit output, used in stage 2.

Test Plan:
- Normal products, out_ready=1, back-to-back:
  - 0x3C00*0x3C00 -> 0x3C00, 2 cycles after accept.
  - 0x4000*0xC200 -> 0xC600 next cycle, tags preserved in order.
- Rounding: 0x3C01*0x3C01 -> 0x3C02 (G=0, S=1, no increment).
- Overflow: 0x7BFF*0x4000 -> 0x7C00.
- Specials:
  - 0x7C00*0x0000 -> 0x7E00.
  - 0xFC00*0x4000 -> 0xFC00.
  - 0x7E01*0x3C00 -> 0x7E00.
- Subnormal input and flush-to-zero:
  - 0x0001*0x7000 -> 0x1000.
  - 0x0400*0x3800 -> 0x0000.
  - 0x8400*0x3800 -> 0x8000.
- Backpressure and reset:
  - Hold out_ready=0 and offer 3 ops -> 2 accepted, then in_ready=0, with prod_out/tag_out stable.
  - Release -> all 3 emerge in order.
  - Assert nRST=0 for 1 cycle with 2 ops in flight -> out_valid=0 next cycle and neither op is emitted.

Source files
------------

// File: rtl/fp16_pkg.sv
// fp16_pkg: binary16 field layout, constants and operand classification.
`default_nettype none

package fp16_pkg;

  localparam int EXP_W  = 5;
  localparam int FRAC_W = 10;
  localparam int BIAS   = 15;

  localparam logic [EXP_W-1:0] EXP_MAX      = 5'h1F;
  localparam logic [15:0]      QNAN_DEFAULT = 16'h7E00;

  typedef struct packed {
    logic              sign;
    logic [EXP_W-1:0]  exp;
    logic [FRAC_W-1:0] frac;
  } fp16_t;

  typedef struct packed {
    logic is_nan;
    logic is_inf;
    logic is_zero;
    logic is_sub;
  } fp16_class_t;

  function automatic fp16_class_t fp16_decode(input fp16_t x);
    fp16_class_t c;
    c.is_nan  = (x.exp == EXP_MAX) && (x.frac != '0);
    c.is_inf  = (x.exp == EXP_MAX) && (x.frac == '0);
    c.is_zero = (x.exp == '0) && (x.frac == '0);
    c.is_sub  = (x.exp == '0) && (x.frac != '0);
    return c;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mul_fp16_pipe_lzc22.sv
// lzc22: combinational leading-zero count of a 22-bit vector (22 when all zero).
`default_nettype none

module lzc22 (
  input  logic [21:0] value,
  output logic [4:0]  count
);

  logic found;

  always_comb begin
    count = '0;
    found = 1'b0;
    for (int i = 21; i >= 0; i--) begin
      if (!found) begin
        if (value[i]) found = 1'b1;
        else          count = count + 5'd1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/mul_fp16_pipe.sv
// mul_fp16_pipe: two-stage binary16 multiplier (decode/multiply, normalize/round)
// with valid/ready flow control and a sideband tag; flush-to-zero on underflow.
`default_nettype none

module mul_fp16_pipe
  import fp16_pkg::*;
#(
  parameter int          TAG_W = 4,
  parameter logic [15:0] QNAN  = QNAN_DEFAULT
) (
  input  logic             clk,
  input  logic             nRST,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      a_in,
  input  logic [15:0]      b_in,
  input  logic [TAG_W-1:0] tag_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [15:0]      prod_out,
  output logic [TAG_W-1:0] tag_out
);

  logic adv1, adv2;

  // Stage-1 registers
  logic              s1_v;
  logic              s1_sign;
  logic signed [6:0] s1_esum;
  logic [21:0]       s1_p;
  logic              s1_spec;
  logic [15:0]       s1_spec_val;
  logic [TAG_W-1:0]  s1_tag;

  // Stage-2 registers drive the outputs directly
  logic              s2_v;
  logic [15:0]       s2_prod;
  logic [TAG_W-1:0]  s2_tag;

  assign adv2      = !s2_v || out_ready;
  assign adv1      = !s1_v || adv2;
  assign in_ready  = adv1;
  assign out_valid = s2_v;
  assign prod_out  = s2_prod;
  assign tag_out   = s2_tag;

  // ---------------- stage 1: decode + multiply ----------------
  fp16_t       a, b;
  fp16_class_t ca, cb;
  logic [4:0]  eff_a, eff_b;
  logic [10:0] man_a, man_b;
  logic        sign;
  logic [21:0] p;
  logic signed [6:0] esum;
  logic        spec;
  logic [15:0] spec_val;

  assign a     = a_in;
  assign b     = b_in;
  assign ca    = fp16_decode(a);
  assign cb    = fp16_decode(b);
  assign sign  = a.sign ^ b.sign;
  assign eff_a = (a.exp == '0) ? 5'd1 : a.exp;
  assign eff_b = (b.exp == '0) ? 5'd1 : b.exp;
  assign man_a = {~(ca.is_sub | ca.is_zero), a.frac};
  assign man_b = {~(cb.is_sub | cb.is_zero), b.frac};
  assign p     = {11'b0, man_a} * {11'b0, man_b};
  assign esum  = $signed({2'b00, eff_a}) + $signed({2'b00, eff_b}) - $signed(7'(BIAS));

  always_comb begin
    spec     = 1'b0;
    spec_val = '0;
    if (ca.is_nan || cb.is_nan) begin
      spec     = 1'b1;
      spec_val = QNAN;
    end else if ((ca.is_inf && cb.is_zero) || (cb.is_inf && ca.is_zero)) begin
      spec     = 1'b1;
      spec_val = QNAN;
    end else if (ca.is_inf || cb.is_inf) begin
      spec     = 1'b1;
      spec_val = {sign, EXP_MAX, 10'b0};
    end else if (ca.is_zero || cb.is_zero) begin
      spec     = 1'b1;
      spec_val = {sign, 15'b0};
    end
  end

  always_ff @(posedge clk) begin
    if (!nRST) begin
      s1_v        <= 1'b0;
      s1_sign     <= 1'b0;
      s1_esum     <= '0;
      s1_p        <= '0;
      s1_spec     <= 1'b0;
      s1_spec_val <= '0;
      s1_tag      <= '0;
    end else if (adv1) begin
      s1_v        <= in_valid;
      s1_sign     <= sign;
      s1_esum     <= esum;
      s1_p        <= p;
      s1_spec     <= spec;
      s1_spec_val <= spec_val;
      s1_tag      <= tag_in;
    end
  end

  // ---------------- stage 2: normalize + round ----------------
  logic [4:0]        lz;
  logic [21:0]       n;
  logic signed [7:0] e_pre, e_fin;
  logic [9:0]        frac;
  logic              guard, sticky, inc;
  logic [10:0]       frac_r;
  logic [15:0]       result;

  lzc22 u_lzc (
    .value (s1_p),
    .count (lz)
  );

  assign n      = s1_p << lz;
  assign e_pre  = $signed({s1_esum[6], s1_esum}) + 8'sd1 - $signed({3'b000, lz});
  assign frac   = n[20:11];
  assign guard  = n[10];
  assign sticky = |n[9:0];
  assign inc    = guard & (sticky | frac[0]);
  assign frac_r = {1'b0, frac} + {10'b0, inc};
  // A rounding carry leaves frac_r[9:0] at zero, so only the exponent moves.
  assign e_fin  = e_pre + $signed({7'b0, frac_r[10]});

  always_comb begin
    result = {s1_sign, e_fin[4:0], frac_r[9:0]};
    if (s1_spec) begin
      result = s1_spec_val;
    end else if (!n[21] || e_pre <= 8'sd0) begin
      result = {s1_sign, 15'b0};
    end else if (e_fin >= 8'sd31) begin
      result = {s1_sign, EXP_MAX, 10'b0};
    end
  end

  always_ff @(posedge clk) begin
    if (!nRST) begin
      s2_v    <= 1'b0;
      s2_prod <= '0;
      s2_tag  <= '0;
    end else if (adv2) begin
      s2_v    <= s1_v;
      s2_prod <= result;
      s2_tag  <= s1_tag;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mul_fp16_pipe.sv
// tb_mul_fp16_pipe: directed and randomized checks of mul_fp16_pipe against an
// arithmetic binary16 product model.
`default_nettype none

module tb_mul_fp16_pipe;

  localparam int TAG_W = 4;

  logic             clk = 1'b0;
  logic             nRST;
  logic             in_valid;
  logic             in_ready;
  logic [15:0]      a_in, b_in;
  logic [TAG_W-1:0] tag_in;
  logic             out_valid;
  logic             out_ready;
  logic [15:0]      prod_out;
  logic [TAG_W-1:0] tag_out;

  int checks = 0;
  int errors = 0;
  logic [TAG_W+15:0] exp_q[$];

  always #5 clk = ~clk;

  mul_fp16_pipe #(.TAG_W(TAG_W), .QNAN(16'h7E00)) dut (
    .clk       (clk),
    .nRST      (nRST),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a_in      (a_in),
    .b_in      (b_in),
    .tag_in    (tag_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .prod_out  (prod_out),
    .tag_out   (tag_out)
  );

  // Exact product P * 2^(effA+effB-50), rounded to 11 significant bits (RNE).
  function automatic logic [15:0] ref_mul(input logic [15:0] a, input logic [15:0] b);
    int ea, eb, fa, fb, msb, biased, shift;
    longint p, q, rem, half;
    logic s;
    logic [4:0] be;
    logic [9:0] bf;
    ea = int'(a[14:10]); eb = int'(b[14:10]);
    fa = int'(a[9:0]);   fb = int'(b[9:0]);
    s  = a[15] ^ b[15];
    if ((ea == 31 && fa != 0) || (eb == 31 && fb != 0)) return 16'h7E00;
    if ((ea == 31 && eb == 0 && fb == 0) || (eb == 31 && ea == 0 && fa == 0)) return 16'h7E00;
    if (ea == 31 || eb == 31) return {s, 5'h1F, 10'h000};
    p = longint'(ea == 0 ? fa : fa + 1024) * longint'(eb == 0 ? fb : fb + 1024);
    if (p == 0) return {s, 15'b0};
    msb = 0;
    for (int i = 0; i < 22; i++) if (((p >> i) & 1) != 0) msb = i;
    biased = msb + (ea == 0 ? 1 : ea) + (eb == 0 ? 1 : eb) - 50 + 15;
    if (biased <= 0) return {s, 15'b0};
    shift = msb - 10;
    if (shift > 0) begin
      q    = p >> shift;
      rem  = p - (q << shift);
      half = longint'(1) << (shift - 1);
      if (rem > half || (rem == half && (q % 2) == 1)) q = q + 1;
    end else begin
      q = p << (-shift);
    end
    if (q == 2048) begin
      q = 1024;
      biased = biased + 1;
    end
    if (biased >= 31) return {s, 5'h1F, 10'h000};
    be = 5'(biased);
    bf = 10'(q - 1024);
    return {s, be, bf};
  endfunction

  function automatic logic [15:0] rand_fp16();
    logic [15:0] v;
    int k;
    v = 16'($urandom);
    k = $urandom_range(0, 11);
    case (k)
      0:       v[14:10] = 5'h1F;
      1:       v[14:10] = 5'h00;
      2:       v[14:0]  = 15'h0;
      3:       v[14:10] = 5'($urandom_range(26, 30));
      4:       v[14:10] = 5'($urandom_range(1, 5));
      default: v[14:10] = 5'($urandom_range(8, 22));
    endcase
    return v;
  endfunction

  task automatic test_reset();
    nRST = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
    a_in = 16'h3C00; b_in = 16'h3C00; tag_in = 4'hF;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0 || prod_out !== 16'h0 || tag_out !== 4'h0) begin
      errors++;
      $display("FAIL reset_state: out_valid=%b prod=%h tag=%h, required 0/0000/0", out_valid, prod_out, tag_out);
    end
    @(negedge clk);
    nRST = 1'b1; in_valid = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready: got %b required 1", in_ready);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1;
    in_valid = 1'b1; a_in = 16'h3C00; b_in = 16'h3C00; tag_in = 4'h5;
    @(negedge clk);
    a_in = 16'h4000; b_in = 16'hC200; tag_in = 4'hA;
    #1;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL latency_early: out_valid=%b required 0 one cycle after accept", out_valid);
    end
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b1 || prod_out !== 16'h3C00 || tag_out !== 4'h5) begin
      errors++;
      $display("FAIL latency_first: v=%b prod=%h tag=%h, required 1/3c00/5", out_valid, prod_out, tag_out);
    end
    @(negedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b1 || prod_out !== 16'hC600 || tag_out !== 4'hA) begin
      errors++;
      $display("FAIL b2b_second: v=%b prod=%h tag=%h, required 1/c600/a", out_valid, prod_out, tag_out);
    end
    @(negedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL b2b_drain: out_valid=%b required 0", out_valid);
    end
    @(negedge clk);
  endtask

  task automatic test_vectors();
    localparam int N = 11;
    logic [15:0] va [N] = '{16'h3C00, 16'h4000, 16'h3C01, 16'h7BFF, 16'h7C00, 16'hFC00,
                            16'h7E01, 16'h0001, 16'h0400, 16'h8400, 16'h8000};
    logic [15:0] vb [N] = '{16'h3C00, 16'hC200, 16'h3C01, 16'h4000, 16'h0000, 16'h4000,
                            16'h3C00, 16'h7000, 16'h3800, 16'h3800, 16'h3C00};
    logic [15:0] vr [N] = '{16'h3C00, 16'hC600, 16'h3C02, 16'h7C00, 16'h7E00, 16'hFC00,
                            16'h7E00, 16'h1000, 16'h0000, 16'h8000, 16'h8000};
    int nout = 0;
    out_ready = 1'b1;
    for (int i = 0; i < N + 4; i++) begin
      in_valid = (i < N);
      a_in   = (i < N) ? va[i] : 16'h0;
      b_in   = (i < N) ? vb[i] : 16'h0;
      tag_in = 4'(i);
      #1;
      if (out_valid) begin
        checks++;
        if (nout >= N) begin
          errors++;
          $display("FAIL vector_extra: unexpected output %h", prod_out);
        end else if (prod_out !== vr[nout] || tag_out !== 4'(nout)) begin
          errors++;
          $display("FAIL vector_%0d: %h*%h got %h tag %h, required %h tag %h",
                   nout, va[nout], vb[nout], prod_out, tag_out, vr[nout], 4'(nout));
        end
        nout++;
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    checks++;
    if (nout != N) begin
      errors++;
      $display("FAIL vector_count: got %0d outputs required %0d", nout, N);
    end
  endtask

  task automatic test_backpressure();
    logic [15:0]      oa [3] = '{16'h3C00, 16'h4200, 16'h3800};
    logic [15:0]      ob [3] = '{16'h4000, 16'h4200, 16'h3800};
    logic [15:0]      orr[3] = '{16'h4000, 16'h4880, 16'h3400};
    logic             rdy[4] = '{1'b1, 1'b1, 1'b0, 1'b0};
    int idx = 0;
    int nout = 0;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int c = 0; c < 4; c++) begin
      a_in = oa[idx]; b_in = ob[idx]; tag_in = 4'(idx + 1);
      #1;
      checks++;
      if (in_ready !== rdy[c]) begin
        errors++;
        $display("FAIL bp_in_ready_c%0d: got %b required %b", c, in_ready, rdy[c]);
      end
      if (c >= 2) begin
        checks++;
        if (out_valid !== 1'b1 || prod_out !== 16'h4000 || tag_out !== 4'h1) begin
          errors++;
          $display("FAIL bp_hold_c%0d: v=%b prod=%h tag=%h, required 1/4000/1", c, out_valid, prod_out, tag_out);
        end
      end
      if (in_valid && in_ready) idx++;
      @(negedge clk);
    end
    for (int c = 0; c < 8; c++) begin
      out_ready = 1'b1;
      in_valid  = (idx < 3);
      if (idx < 3) begin
        a_in = oa[idx]; b_in = ob[idx]; tag_in = 4'(idx + 1);
      end
      #1;
      if (out_valid) begin
        checks++;
        if (nout >= 3) begin
          errors++;
          $display("FAIL bp_extra: unexpected output %h", prod_out);
        end else if (prod_out !== orr[nout] || tag_out !== 4'(nout + 1)) begin
          errors++;
          $display("FAIL bp_order_%0d: got %h tag %h, required %h tag %h",
                   nout, prod_out, tag_out, orr[nout], 4'(nout + 1));
        end
        nout++;
      end
      if (in_valid && in_ready) idx++;
      @(negedge clk);
    end
    in_valid = 1'b0;
    checks++;
    if (nout != 3 || idx != 3) begin
      errors++;
      $display("FAIL bp_count: outputs %0d accepted %0d, required 3/3", nout, idx);
    end
  endtask

  task automatic test_reset_midflight();
    int seen = 0;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    a_in = 16'h4000; b_in = 16'h4000; tag_in = 4'h7;
    @(negedge clk);
    a_in = 16'h4400; b_in = 16'h4000; tag_in = 4'h8;
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b1) begin
      errors++;
      $display("FAIL midreset_inflight: out_valid=%b required 1 before reset", out_valid);
    end
    nRST = 1'b0;
    @(negedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0 || prod_out !== 16'h0 || tag_out !== 4'h0) begin
      errors++;
      $display("FAIL midreset_clear: v=%b prod=%h tag=%h, required 0/0000/0", out_valid, prod_out, tag_out);
    end
    nRST = 1'b1;
    out_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      #1;
      if (out_valid) seen++;
    end
    checks++;
    if (seen != 0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL midreset_discard: %0d stale outputs, in_ready=%b, required 0 and 1", seen, in_ready);
    end
    @(negedge clk);
  endtask

  task automatic test_random();
    localparam int N = 400;
    int sent = 0;
    int cyc  = 0;
    logic stall_prev = 1'b0;
    logic [TAG_W+15:0] prev_out = '0;
    logic [TAG_W+15:0] exp;
    exp_q.delete();
    while ((sent < N || exp_q.size() > 0) && cyc < 6000) begin
      in_valid  = (sent < N) && ($urandom_range(0, 9) < 8);
      a_in      = rand_fp16();
      b_in      = rand_fp16();
      tag_in    = 4'($urandom);
      out_ready = ($urandom_range(0, 9) < 6);
      #1;
      if (stall_prev) begin
        checks++;
        if (out_valid !== 1'b1 || {tag_out, prod_out} !== prev_out) begin
          errors++;
          $display("FAIL rand_stall_hold: v=%b tag/prod=%h, required 1/%h", out_valid, {tag_out, prod_out}, prev_out);
        end
      end
      if (out_valid && out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL rand_extra: unexpected output %h", prod_out);
        end else begin
          exp = exp_q.pop_front();
          if ({tag_out, prod_out} !== exp) begin
            errors++;
            $display("FAIL rand_product: got prod %h tag %h, required prod %h tag %h",
                     prod_out, tag_out, exp[15:0], exp[TAG_W+15:16]);
          end
        end
      end
      stall_prev = out_valid && !out_ready;
      prev_out   = {tag_out, prod_out};
      if (in_valid && in_ready) begin
        exp_q.push_back({tag_in, ref_mul(a_in, b_in)});
        sent++;
      end
      cyc++;
      @(negedge clk);
    end
    in_valid = 1'b0;
    checks++;
    if (sent != N || exp_q.size() != 0) begin
      errors++;
      $display("FAIL rand_drain: accepted %0d of %0d, %0d still pending", sent, N, exp_q.size());
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    nRST = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    a_in = '0; b_in = '0; tag_in = '0;
    @(negedge clk);
    test_reset();
    test_back_to_back();
    test_vectors();
    test_backpressure();
    test_reset_midflight();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
